apb_turret_pwm: RTL and testbench
=================================

// Module: apb_turret_pwm
// PURPOSE
//  APB3 fabric slave on the MSS master bus (MSSPSEL/MSSPENABLE/...). Drives turret
//  pan/tilt servo PWM and a timed fire one-shot. Firmware programs period, duties and
//  fire length. Duties are double-buffered so servo updates land on frame boundaries.
// PARAMETERS
//  CNT_W        21        counter/period/duty width; 2^21 > 20 ms at 100 MHz FAB_CLK
//  RST_PERIOD   2000000   reset PERIOD, 20 ms frame
//  RST_DUTY     150000    reset duty for both channels, 1.5 ms servo centre
//  FIRE_W       24        FIRE_LEN width
//  HOLDOFF      10000000  post-fire lockout in cycles, 100 ms
// PORTS
//  FAB_CLK    in   1   fabric clock from MSS CCC; the only clock
//  FAB_RESET  in   1   synchronous, active-high reset; top level drives it as ~M2F_RESET_N
//  PSEL       in   1   APB select
//  PENABLE    in   1   APB enable
//  PWRITE     in   1   APB write
//  PADDR      in   8   byte address; [1:0] ignored
//  PWDATA     in   32  APB write data
//  PRDATA     out  32  APB read data
//  PREADY     out  1   tied 1; zero wait states
//  PSLVERR    out  1   error for an unmapped address or an illegal PERIOD
//  PWM_PAN    out  1   pan servo PWM
//  PWM_TILT   out  1   tilt servo PWM
//  FIRE_OUT   out  1   trigger solenoid pulse
// BEHAVIOUR
//  Register map (reads return 0 in unused bits):
//   0x00 CTRL      [0] EN, R/W. [1] FIRE, write 1 to request a shot; reads 0.
//   0x04 PERIOD    pending frame length in cycles.
//   0x08 DUTY_PAN  pending high time in cycles.
//   0x0C DUTY_TILT pending high time in cycles.
//   0x10 FIRE_LEN  pulse length in cycles.
//   0x14 STATUS    [0] FIRE_BUSY, RO. [1] FRAME, sticky, write-1-clear.
//                  [2] FIRE_DROP, sticky, write-1-clear.
//  APB timing:
//   - Write commits on PSEL&PENABLE&PWRITE.
//   - PRDATA is registered on the setup phase (PSEL&!PENABLE&!PWRITE) and held through access.
//   - PSLVERR is combinational in the access phase only: unmapped address, or PERIOD write <2.
//   - An illegal write has no effect.
//  Reset values:
//   - Outputs: PRDATA=0, PSLVERR=0, PWM_*=0, FIRE_OUT=0.
//   - Registers: EN=0, PERIOD=RST_PERIOD, duties=RST_DUTY, FIRE_LEN=0, STATUS=0.
//   - Fire FSM=IDLE.
//  PWM frame:
//   - cnt counts 0..act_period-1 and wraps.
//   - PWM_x = EN && (cnt < act_duty_x). Duty >= period gives constant high; duty 0 gives constant low.
//   - EN=0: cnt held at 0, PWM_x=0, active regs track pending every cycle.
//   - EN 0->1: the first frame starts at cnt=0 on the next cycle.
//   - At wrap (cnt==act_period-1) active regs load pending and FRAME sets.
//   - Pending write in the same cycle as a wrap: the old pending value is loaded; the new one applies next frame.
//   - FRAME set and W1C in the same cycle: set wins.
//  Fire FSM (IDLE, PULSE, LOCK):
//   - IDLE: FIRE write with FIRE_LEN!=0 -> PULSE, load timer=FIRE_LEN. FIRE_LEN==0 -> ignored.
//   - PULSE: FIRE_OUT=1 for exactly FIRE_LEN cycles, starting the cycle after the write -> LOCK.
//   - LOCK: FIRE_OUT=0 for HOLDOFF cycles -> IDLE.
//   - FIRE_BUSY = (state != IDLE).
//   - FIRE write while busy: ignored and FIRE_DROP sets.
//   - Fire operation is independent of EN.
//  FAB_RESET mid-frame or mid-pulse returns all state to reset values on the next edge;
//  FIRE_OUT drops within one cycle.
// STRUCTURE
//  Shared package turret_pkg:
//   - register offsets, CTRL/STATUS bit indices
//   - fire FSM state enum
//   - RST_PERIOD/RST_DUTY defaults
//  One sub-module, pwm_channel: compares the shared cnt against its own double-buffered duty.
//   - Instantiated twice (pan, tilt).
//   - The frame counter and APB decode stay in apb_turret_pwm.
// TESTING
//  1. After reset:
//     - read PERIOD -> 2000000; DUTY_PAN -> 150000
//     - PWM_* low; PREADY=1 on every access
//  2. Set PERIOD=100, DUTY_PAN=25, DUTY_TILT=100, EN=1:
//     - PWM_PAN high 25 of every 100 cycles
//     - PWM_TILT constant high
//     - FRAME sets at every wrap
//  3. Write DUTY_PAN=60 mid-frame (cnt=40):
//     - current frame still ends high at 25 cycles
//     - next frame is high 60 cycles
//     - repeat with the write landing on the wrap cycle -> 60 applies one frame later
//  4. FIRE_LEN=5, write CTRL.FIRE=1 (HOLDOFF=20 in the bench):
//     - FIRE_OUT high exactly 5 cycles
//     - BUSY for 25 cycles total
//     - second FIRE during LOCK -> no pulse, FIRE_DROP=1
//     - W1C clears FIRE_DROP
//  5. Error cases:
//     - access 0x18 -> PSLVERR=1, PRDATA=0
//     - write PERIOD=1 -> PSLVERR=1, PERIOD unchanged
//  6. Reset mid-operation:
//     - assert FAB_RESET mid-PULSE and mid-frame -> next edge FIRE_OUT=0, PWM_*=0, registers at reset values
//     - FRAME W1C coincident with a wrap -> FRAME stays 1

Source files
------------

// File: rtl/turret_pkg.sv
// Shared definitions for the turret PWM/fire APB slave: register map,
// bit positions, fire sequencer states and reset defaults.
package turret_pkg;

  localparam int unsigned RST_PERIOD = 2000000;
  localparam int unsigned RST_DUTY   = 150000;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_PERIOD    = 8'h04;
  localparam logic [7:0] REG_DUTY_PAN  = 8'h08;
  localparam logic [7:0] REG_DUTY_TILT = 8'h0C;
  localparam logic [7:0] REG_FIRE_LEN  = 8'h10;
  localparam logic [7:0] REG_STATUS    = 8'h14;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FIRE  = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FRAME = 1;
  localparam int STAT_DROP  = 2;

  typedef enum logic [1:0] {
    FIRE_IDLE  = 2'd0,
    FIRE_PULSE = 2'd1,
    FIRE_LOCK  = 2'd2
  } fire_state_t;

endpackage

// File: rtl/pwm_channel.sv
// One servo channel: pending/active duty pair compared against the shared
// frame counter. The active duty only moves at a frame wrap or while disabled.
module pwm_channel #(
  parameter int          CNT_W    = 21,
  parameter int unsigned RST_DUTY = turret_pkg::RST_DUTY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wrap,
  input  logic             wr,
  input  logic [CNT_W-1:0] wdata,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] duty_pend,
  output logic             pwm
);
  import turret_pkg::*;

  logic [CNT_W-1:0] duty_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_pend <= CNT_W'(RST_DUTY);
      duty_act  <= CNT_W'(RST_DUTY);
    end else begin
      if (wr) duty_pend <= wdata;
      // A write landing on the wrap cycle is seen here only on the next wrap.
      if (!en || wrap) duty_act <= duty_pend;
    end
  end

  assign pwm = en && (cnt < duty_act);

endmodule

// File: rtl/apb_turret_pwm.sv
// APB3 slave driving pan/tilt servo PWM with frame-aligned duty updates and a
// timed fire one-shot followed by a lockout.
module apb_turret_pwm #(
  parameter int          CNT_W      = 21,
  parameter int unsigned RST_PERIOD = turret_pkg::RST_PERIOD,
  parameter int unsigned RST_DUTY   = turret_pkg::RST_DUTY,
  parameter int          FIRE_W     = 24,
  parameter int unsigned HOLDOFF    = 10000000
) (
  input  logic        FAB_CLK,
  input  logic        FAB_RESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        PWM_PAN,
  output logic        PWM_TILT,
  output logic        FIRE_OUT
);
  import turret_pkg::*;

  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam int TMR_W  = (FIRE_W > HOLD_W) ? FIRE_W : HOLD_W;

  logic [7:0]        addr;
  logic              mapped, access, bad_period, wr_ok, setup_rd;
  logic              wr_ctrl, wr_period, wr_pan, wr_tilt, wr_fire_len, wr_status;
  logic              fire_req, drop_set, busy;
  logic              en, frame, drop, wrap;
  logic [CNT_W-1:0]  period_pend, period_act, cnt;
  logic [CNT_W-1:0]  duty_pan_pend, duty_tilt_pend;
  logic [FIRE_W-1:0] fire_len;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [31:0]       rdata;
  logic              unused_bits;
  fire_state_t       state, state_nxt;

  assign addr        = {PADDR[7:2], 2'b00};
  assign unused_bits = ^PADDR[1:0];

  always_comb begin
    mapped = 1'b0;
    case (addr)
      REG_CTRL, REG_PERIOD, REG_DUTY_PAN,
      REG_DUTY_TILT, REG_FIRE_LEN, REG_STATUS: mapped = 1'b1;
      default: mapped = 1'b0;
    endcase
  end

  assign access      = PSEL && PENABLE;
  assign setup_rd    = PSEL && !PENABLE && !PWRITE;
  assign bad_period  = PWRITE && (addr == REG_PERIOD) && (PWDATA < 32'd2);
  assign PSLVERR     = access && (!mapped || bad_period);
  assign PREADY      = 1'b1;
  assign wr_ok       = access && PWRITE && mapped && !bad_period;
  assign wr_ctrl     = wr_ok && (addr == REG_CTRL);
  assign wr_period   = wr_ok && (addr == REG_PERIOD);
  assign wr_pan      = wr_ok && (addr == REG_DUTY_PAN);
  assign wr_tilt     = wr_ok && (addr == REG_DUTY_TILT);
  assign wr_fire_len = wr_ok && (addr == REG_FIRE_LEN);
  assign wr_status   = wr_ok && (addr == REG_STATUS);
  assign fire_req    = wr_ctrl && PWDATA[CTRL_FIRE];

  always_comb begin
    rdata = '0;
    case (addr)
      REG_CTRL:      rdata[CTRL_EN]      = en;
      REG_PERIOD:    rdata[CNT_W-1:0]    = period_pend;
      REG_DUTY_PAN:  rdata[CNT_W-1:0]    = duty_pan_pend;
      REG_DUTY_TILT: rdata[CNT_W-1:0]    = duty_tilt_pend;
      REG_FIRE_LEN:  rdata[FIRE_W-1:0]   = fire_len;
      REG_STATUS: begin
        rdata[STAT_BUSY]  = busy;
        rdata[STAT_FRAME] = frame;
        rdata[STAT_DROP]  = drop;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) PRDATA <= '0;
    else if (setup_rd) PRDATA <= rdata;
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      en          <= 1'b0;
      period_pend <= CNT_W'(RST_PERIOD);
      fire_len    <= '0;
      frame       <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (wr_ctrl)     en          <= PWDATA[CTRL_EN];
      if (wr_period)   period_pend <= PWDATA[CNT_W-1:0];
      if (wr_fire_len) fire_len    <= PWDATA[FIRE_W-1:0];
      // Hardware set takes priority over a coincident write-1-clear.
      if (wrap) frame <= 1'b1;
      else if (wr_status && PWDATA[STAT_FRAME]) frame <= 1'b0;
      if (drop_set) drop <= 1'b1;
      else if (wr_status && PWDATA[STAT_DROP]) drop <= 1'b0;
    end
  end

  assign wrap = en && (cnt == period_act - CNT_W'(1));

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      cnt        <= '0;
      period_act <= CNT_W'(RST_PERIOD);
    end else if (!en || wrap) begin
      cnt        <= '0;
      period_act <= period_pend;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  pwm_channel #(.CNT_W(CNT_W), .RST_DUTY(RST_DUTY)) u_pan (
    .clk(FAB_CLK), .rst(FAB_RESET), .en(en), .wrap(wrap), .wr(wr_pan),
    .wdata(PWDATA[CNT_W-1:0]), .cnt(cnt), .duty_pend(duty_pan_pend), .pwm(PWM_PAN)
  );

  pwm_channel #(.CNT_W(CNT_W), .RST_DUTY(RST_DUTY)) u_tilt (
    .clk(FAB_CLK), .rst(FAB_RESET), .en(en), .wrap(wrap), .wr(wr_tilt),
    .wdata(PWDATA[CNT_W-1:0]), .cnt(cnt), .duty_pend(duty_tilt_pend), .pwm(PWM_TILT)
  );

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      state <= FIRE_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // timer holds the cycles remaining in PULSE or LOCK, terminal count at 1
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    drop_set  = 1'b0;
    case (state)
      FIRE_IDLE: begin
        if (fire_req && (fire_len != '0)) begin
          state_nxt = FIRE_PULSE;
          timer_nxt = TMR_W'(fire_len);
        end
      end
      FIRE_PULSE: begin
        drop_set = fire_req;
        if (timer == TMR_W'(1)) begin
          state_nxt = FIRE_LOCK;
          timer_nxt = TMR_W'(HOLDOFF);
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      FIRE_LOCK: begin
        drop_set = fire_req;
        if (timer == TMR_W'(1)) state_nxt = FIRE_IDLE;
        else timer_nxt = timer - TMR_W'(1);
      end
      default: state_nxt = FIRE_IDLE;
    endcase
  end

  assign busy     = (state != FIRE_IDLE);
  assign FIRE_OUT = (state == FIRE_PULSE);

endmodule

// File: tb/tb_apb_turret_pwm.sv
// Self-checking bench for apb_turret_pwm: register vector table plus directed
// sequences for frame timing, double buffering, fire/lockout and reset.
module tb_apb_turret_pwm;

  localparam int HOLD = 20;

  logic        FAB_CLK = 1'b0;
  logic        FAB_RESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, PWM_PAN, PWM_TILT, FIRE_OUT;

  apb_turret_pwm #(.HOLDOFF(HOLD)) dut (
    .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PWM_PAN(PWM_PAN), .PWM_TILT(PWM_TILT),
    .FIRE_OUT(FIRE_OUT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int cyc = 0;
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_en = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d,
                           output logic err, output logic rdy);
    @(posedge FAB_CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge FAB_CLK); #1;
    PENABLE = 1'b1;
    #1;
    err = PSLVERR;
    rdy = PREADY;
    @(posedge FAB_CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d,
                          output logic err, output logic rdy);
    @(posedge FAB_CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge FAB_CLK); #1;
    PENABLE = 1'b1;
    #1;
    d   = PRDATA;
    err = PSLVERR;
    rdy = PREADY;
    @(posedge FAB_CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic e, r;
    apb_write(a, d, e, r);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    logic e, r;
    apb_read(a, d, e, r);
  endtask

  task automatic run_vec(input int i);
    logic [31:0] d;
    logic e, r;
    string tag;
    tag = $sformatf("vec%0d_a%02h", i, vecs[i].addr);
    if (vecs[i].wr) begin
      apb_write(vecs[i].addr, vecs[i].wdata, e, r);
    end else begin
      apb_read(vecs[i].addr, d, e, r);
      check({tag, "_rdata"}, d, vecs[i].exp_rdata);
    end
    check({tag, "_pslverr"}, 32'(e), 32'(vecs[i].exp_err));
    check({tag, "_pready"}, 32'(r), 32'd1);
  endtask

  function automatic int phase();
    return (cyc - n_en) % 100;
  endfunction

  task automatic wait_phase(input int p);
    for (int k = 0; k < 300 && phase() != p; k++) begin
      @(posedge FAB_CLK); #1;
    end
    if (phase() != p) timeout_fail("wait_phase");
  endtask

  task automatic wait_cyc(input int t);
    for (int k = 0; k < 1000 && cyc < t; k++) begin
      @(posedge FAB_CLK); #1;
    end
    if (cyc < t) timeout_fail("wait_cyc");
  endtask

  task automatic count_pan(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      if (PWM_PAN) hi++;
      @(posedge FAB_CLK); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int hi, hi0, hi1, mism, tilt_lo, m, m2, m3;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,     32'h0,      1'b0};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,     32'd2000000, 1'b0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,     32'd150000, 1'b0};
    vecs[3]  = '{1'b0, 8'h0C, 32'h0,     32'd150000, 1'b0};
    vecs[4]  = '{1'b0, 8'h10, 32'h0,     32'h0,      1'b0};
    vecs[5]  = '{1'b0, 8'h14, 32'h0,     32'h0,      1'b0};
    vecs[6]  = '{1'b0, 8'h18, 32'h0,     32'h0,      1'b1};
    vecs[7]  = '{1'b1, 8'h04, 32'd1,     32'h0,      1'b1};
    vecs[8]  = '{1'b0, 8'h04, 32'h0,     32'd2000000, 1'b0};
    vecs[9]  = '{1'b1, 8'h1C, 32'd7,     32'h0,      1'b1};
    vecs[10] = '{1'b1, 8'h10, 32'h12345, 32'h0,      1'b0};
    vecs[11] = '{1'b0, 8'h10, 32'h0,     32'h12345,  1'b0};
    vecs[12] = '{1'b1, 8'h04, 32'd0,     32'h0,      1'b1};
    vecs[13] = '{1'b1, 8'h04, 32'd2,     32'h0,      1'b0};
    vecs[14] = '{1'b0, 8'h04, 32'h0,     32'd2,      1'b0};
    vecs[15] = '{1'b1, 8'h08, 32'hABC,   32'h0,      1'b0};
    vecs[16] = '{1'b0, 8'h0B, 32'h0,     32'hABC,    1'b0};

    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    FAB_RESET = 1'b1;
    repeat (3) @(posedge FAB_CLK);
    #1;
    FAB_RESET = 1'b0;

    check("rst_pwm_pan", 32'(PWM_PAN), 32'd0);
    check("rst_pwm_tilt", 32'(PWM_TILT), 32'd0);
    check("rst_fire_out", 32'(FIRE_OUT), 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pslverr", 32'(PSLVERR), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Frame timing: period 100, pan 25, tilt saturated high
    wr(8'h04, 32'd100);
    wr(8'h08, 32'd25);
    wr(8'h0C, 32'd100);
    wr(8'h00, 32'd1);
    n_en = cyc;
    mism = 0; hi0 = 0; hi1 = 0; tilt_lo = 0;
    for (int i = 0; i < 200; i++) begin
      if (PWM_PAN !== ((i % 100) < 25)) mism++;
      if (PWM_PAN === 1'b1) begin
        if (i < 100) hi0++;
        else hi1++;
      end
      if (PWM_TILT !== 1'b1) tilt_lo++;
      @(posedge FAB_CLK); #1;
    end
    check("pan_pattern_mismatches", 32'(mism), 32'd0);
    check("pan_high_frame0", 32'(hi0), 32'd25);
    check("pan_high_frame1", 32'(hi1), 32'd25);
    check("tilt_low_cycles", 32'(tilt_lo), 32'd0);

    rd(8'h14, d);
    check("frame_set", d & 32'h2, 32'h2);
    wait_phase(10);
    wr(8'h14, 32'h2);
    rd(8'h14, d);
    check("frame_w1c", d & 32'h2, 32'h0);
    wait_phase(5);
    rd(8'h14, d);
    check("frame_next_wrap", d & 32'h2, 32'h2);

    wait_phase(10);
    wr(8'h14, 32'h2);
    wait_phase(97);
    wr(8'h14, 32'h2);
    rd(8'h14, d);
    check("frame_w1c_at_wrap", d & 32'h2, 32'h2);

    // Mid-frame duty write lands at the next frame
    wait_phase(38);
    wr(8'h08, 32'd60);
    hi = 0;
    for (int k = 0; k < 200 && phase() != 0; k++) begin
      if (PWM_PAN) hi++;
      @(posedge FAB_CLK); #1;
    end
    check("pan_tail_old_duty", 32'(hi), 32'd0);
    count_pan(100, hi);
    check("pan_new_duty", 32'(hi), 32'd60);
    rd(8'h08, d);
    check("duty_pan_readback", d, 32'd60);

    // Duty write on the wrap cycle is deferred one more frame
    wait_phase(38);
    wr(8'h08, 32'd25);
    wait_phase(97);
    wr(8'h08, 32'd60);
    count_pan(100, hi);
    check("pan_wrap_write_deferred", 32'(hi), 32'd25);
    count_pan(100, hi);
    check("pan_wrap_write_applied", 32'(hi), 32'd60);

    // Fire pulse, drop during lockout, W1C of FIRE_DROP
    wr(8'h10, 32'd5);
    wr(8'h00, 32'd3);
    m = cyc;
    mism = 0; hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (FIRE_OUT !== (i < 5)) mism++;
      if (FIRE_OUT === 1'b1) hi++;
      @(posedge FAB_CLK); #1;
    end
    check("fire_pattern_mismatches", 32'(mism), 32'd0);
    check("fire_high_cycles", 32'(hi), 32'd5);
    wr(8'h00, 32'd3);
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (FIRE_OUT) hi++;
      @(posedge FAB_CLK); #1;
    end
    check("fire_in_lock_no_pulse", 32'(hi), 32'd0);
    rd(8'h14, d);
    check("status_busy_drop", d & 32'h5, 32'h5);
    rd(8'h00, d);
    check("ctrl_fire_reads_0", d, 32'd1);
    wr(8'h14, 32'h4);
    rd(8'h14, d);
    check("drop_w1c", d & 32'h4, 32'h0);

    // Busy window edges: 25 cycles after the accepting write
    wait_cyc(m + 40);
    wr(8'h00, 32'd3);
    m2 = cyc;
    wait_cyc(m2 + 22);
    wr(8'h00, 32'd3);
    check("fire_last_lock_cycle_out", 32'(FIRE_OUT), 32'd0);
    rd(8'h14, d);
    check("drop_last_lock_cycle", d & 32'h4, 32'h4);
    wr(8'h14, 32'h4);

    wait_cyc(m2 + 70);
    wr(8'h00, 32'd3);
    m3 = cyc;
    wait_cyc(m3 + 23);
    wr(8'h00, 32'd3);
    check("fire_first_idle_cycle_out", 32'(FIRE_OUT), 32'd1);
    rd(8'h14, d);
    check("no_drop_first_idle_cycle", d & 32'h4, 32'h0);

    // Reset in the middle of a pulse and a frame
    wait_cyc(m3 + 70);
    wr(8'h10, 32'd50);
    wr(8'h00, 32'd3);
    repeat (3) begin
      @(posedge FAB_CLK); #1;
    end
    check("pre_reset_fire_out", 32'(FIRE_OUT), 32'd1);
    check("pre_reset_pwm_tilt", 32'(PWM_TILT), 32'd1);
    FAB_RESET = 1'b1;
    @(posedge FAB_CLK); #1;
    check("reset_fire_out", 32'(FIRE_OUT), 32'd0);
    check("reset_pwm_pan", 32'(PWM_PAN), 32'd0);
    check("reset_pwm_tilt", 32'(PWM_TILT), 32'd0);
    check("reset_prdata", PRDATA, 32'd0);
    FAB_RESET = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
